// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: opcodes, NOP encoding,
// default reset PC, instruction field positions and the fetch mode type.
package mips16_pkg;

    localparam logic [2:0]  OP_RTYPE         = 3'b000;
    localparam logic [2:0]  OP_BRANCH        = 3'b100;
    localparam logic [15:0] NOP              = 16'h0000;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 13;
    localparam int unsigned OFFSET_MSB = 4;
    localparam int unsigned OFFSET_LSB = 0;

    typedef enum logic {
        FETCH,
        HOLD
    } fetch_mode_t;

    // Sign-extend the 5-bit PC-relative branch offset to a full word.
    function automatic logic [15:0] sext_offset(input logic [15:0] instr);
        return {{11{instr[OFFSET_MSB]}}, instr[OFFSET_MSB:OFFSET_LSB]};
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode for static prediction: flags backward PC-relative
// branches as taken and computes their target (PC + 1 + offset, 16-bit wrap).
module fetch_predecode
    import mips16_pkg::*;
#(
    parameter logic [2:0] BRANCH_OP = OP_BRANCH
) (
    input  logic [15:0] Instruction,
    input  logic [15:0] Pc,
    output logic        Predict,
    output logic [15:0] PredTarget
);

    // Backward (negative offset) branches are predicted taken.
    always_comb begin
        Predict    = (Instruction[OPCODE_MSB:OPCODE_LSB] == BRANCH_OP) && Instruction[OFFSET_MSB];
        PredTarget = Pc + 16'd1 + sext_offset(Instruction);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID register. Handles stall, redirect and (optionally) static
// backward-branch prediction, enabled by defining FETCH_STATIC_PREDICT_EN.
module instruction_fetch
    import mips16_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [2:0]  BRANCH_OP = OP_BRANCH
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] InstructionAddress,
    input  logic [15:0] Instruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [15:0] RedirectTarget,
    output logic [15:0] IfIdInstruction,
    output logic [15:0] IfIdPcPlus1,
    output logic        IfIdValid,
    output logic        IfIdPredTaken
);

    logic [15:0] pc_q;
    logic [15:0] pc_plus1;
    logic        predict;
    logic [15:0] pred_target;
    logic        hold;

    fetch_mode_t mode_q;
    fetch_mode_t mode_d;

    assign InstructionAddress = pc_q;
    assign pc_plus1           = pc_q + 16'd1;

`ifdef FETCH_STATIC_PREDICT_EN
    fetch_predecode #(
        .BRANCH_OP(BRANCH_OP)
    ) u_predecode (
        .Instruction(Instruction),
        .Pc         (pc_q),
        .Predict    (predict),
        .PredTarget (pred_target)
    );
`else
    logic unused_branch_op;
    assign unused_branch_op = ^BRANCH_OP;
    assign predict          = 1'b0;
    assign pred_target      = pc_plus1;
`endif

    // Mode state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_q <= FETCH;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode transitions; the hold enable follows the inputs directly so the
    // mode never adds a cycle of latency.
    always_comb begin
        mode_d = mode_q;
        hold   = Stall && !Redirect;
        case (mode_q)
            FETCH:   if (Stall && !Redirect) mode_d = HOLD;
            HOLD:    if (!Stall || Redirect) mode_d = FETCH;
            default: mode_d = FETCH;
        endcase
    end

    // PC and IF/ID register update: Reset > Redirect > Stall > predict > PC+1.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q            <= RESET_PC;
            IfIdInstruction <= NOP;
            IfIdPcPlus1     <= '0;
            IfIdValid       <= 1'b0;
            IfIdPredTaken   <= 1'b0;
        end else if (Redirect) begin
            pc_q            <= RedirectTarget;
            IfIdInstruction <= NOP;
            IfIdPcPlus1     <= '0;
            IfIdValid       <= 1'b0;
            IfIdPredTaken   <= 1'b0;
        end else if (!hold) begin
            pc_q            <= predict ? pred_target : pc_plus1;
            IfIdInstruction <= Instruction;
            IfIdPcPlus1     <= pc_plus1;
            IfIdValid       <= 1'b1;
            IfIdPredTaken   <= predict;
        end
    end

endmodule
